axi4_sram_slave: RTL and testbench

- AXI4 slave responder with internal word-addressed SRAM array, the responder end of the core's io_master AXI4 port.
- Used as an on-chip memory model for the core and for bench-level protocol checking of the core's AXI initiator.
- Write and read channels run independent state machines. Supports FIXED and INCR bursts of 32-bit data.

---
 rtl/axi4_sram_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_slave.sv
// AXI4 slave over an internal word-addressed SRAM with independent write and read FSMs; FIXED/INCR bursts, 32-bit data.
// Define AXI_SRAM_LATENCY_EN to insert LAT wait cycles before the first R beat and before B; rdata is a combinational array read.
module axi4_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0f000000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef AXI_SRAM_LATENCY_EN
  localparam logic [3:0] LAT = 4'd3;
  logic [3:0] w_wait_cnt;
  logic [3:0] r_wait_cnt;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [31:0] mem [DEPTH];

  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_slv;
  logic        w_dec;

  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;

  logic [31:0] w_off;
  logic        w_in;
  logic        w_beat;
  logic        w_final;
  logic        w_dec_nxt;
  logic        w_slv_nxt;
  logic [31:0] r_off;
  logic        r_in;

  // Offsets wrap in 32 bits, so addresses below BASE_ADDR land far above the array.
  assign w_off     = w_addr - BASE_ADDR;
  assign w_in      = (w_off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign w_beat    = io_slave_wvalid && io_slave_wready;
  assign w_final   = (w_cnt == w_len);
  assign w_dec_nxt = w_dec || !w_in;
  assign w_slv_nxt = w_slv || (w_size > 3'd2) || w_burst[1] || (io_slave_wlast != w_final);

  assign r_off = r_addr - BASE_ADDR;
  assign r_in  = (r_off >> (DEPTH_LOG2 + 2)) == 32'd0;

  assign io_slave_rdata = (io_slave_rvalid && r_in) ? mem[r_off[DEPTH_LOG2+1:2]] : 32'h0;
  assign io_slave_rlast = io_slave_rvalid && (r_cnt == r_len);
  assign io_slave_rresp = !io_slave_rvalid ? 2'b00 :
                          !r_in ? 2'b11 :
                          ((r_size > 3'd2) || r_burst[1]) ? 2'b10 : 2'b00;

  always_ff @(posedge clock) begin
    if (w_beat && w_in) begin
      for (int i = 0; i < 4; i++) begin
        if (io_slave_wstrb[i]) mem[w_off[DEPTH_LOG2+1:2]][i*8 +: 8] <= io_slave_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state          <= W_IDLE;
      io_slave_awready <= 1'b0;
      io_slave_wready  <= 1'b0;
      io_slave_bvalid  <= 1'b0;
      io_slave_bresp   <= 2'b00;
      io_slave_bid     <= 4'd0;
      w_addr           <= 32'd0;
      w_len            <= 8'd0;
      w_cnt            <= 8'd0;
      w_size           <= 3'd0;
      w_burst          <= 2'd0;
      w_slv            <= 1'b0;
      w_dec            <= 1'b0;
`ifdef AXI_SRAM_LATENCY_EN
      w_wait_cnt       <= 4'd0;
`endif
    end else begin
      case (w_state)
        W_IDLE: begin
          io_slave_awready <= 1'b1;
          if (io_slave_awvalid && io_slave_awready) begin
            w_addr           <= io_slave_awaddr;
            io_slave_bid     <= io_slave_awid;
            w_len            <= io_slave_awlen;
            w_size           <= io_slave_awsize;
            w_burst          <= io_slave_awburst;
            w_cnt            <= 8'd0;
            w_slv            <= 1'b0;
            w_dec            <= 1'b0;
            io_slave_awready <= 1'b0;
            io_slave_wready  <= 1'b1;
            w_state          <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_slv <= w_slv_nxt;
            w_dec <= w_dec_nxt;
            if (w_final) begin
              io_slave_wready <= 1'b0;
              io_slave_bresp  <= w_dec_nxt ? 2'b11 : (w_slv_nxt ? 2'b10 : 2'b00);
`ifdef AXI_SRAM_LATENCY_EN
              w_wait_cnt      <= 4'd0;
              w_state         <= W_WAIT;
`else
              io_slave_bvalid <= 1'b1;
              w_state         <= W_RESP;
`endif
            end else begin
              w_cnt <= w_cnt + 8'd1;
              if (w_burst != 2'b00) w_addr <= w_addr + (32'd1 << w_size);
            end
          end
        end
`ifdef AXI_SRAM_LATENCY_EN
        W_WAIT: begin
          if (w_wait_cnt == LAT - 4'd1) begin
            io_slave_bvalid <= 1'b1;
            w_state         <= W_RESP;
          end else begin
            w_wait_cnt <= w_wait_cnt + 4'd1;
          end
        end
`endif
        W_RESP: begin
          if (io_slave_bready) begin
            io_slave_bvalid  <= 1'b0;
            io_slave_bresp   <= 2'b00;
            io_slave_awready <= 1'b1;
            w_state          <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= R_IDLE;
      io_slave_arready <= 1'b0;
      io_slave_rvalid  <= 1'b0;
      io_slave_rid     <= 4'd0;
      r_addr           <= 32'd0;
      r_len            <= 8'd0;
      r_cnt            <= 8'd0;
      r_size           <= 3'd0;
      r_burst          <= 2'd0;
`ifdef AXI_SRAM_LATENCY_EN
      r_wait_cnt       <= 4'd0;
`endif
    end else begin
      case (r_state)
        R_IDLE: begin
          io_slave_arready <= 1'b1;
          if (io_slave_arvalid && io_slave_arready) begin
            r_addr           <= io_slave_araddr;
            io_slave_rid     <= io_slave_arid;
            r_len            <= io_slave_arlen;
            r_size           <= io_slave_arsize;
            r_burst          <= io_slave_arburst;
            r_cnt            <= 8'd0;
            io_slave_arready <= 1'b0;
`ifdef AXI_SRAM_LATENCY_EN
            r_wait_cnt       <= 4'd0;
            r_state          <= R_WAIT;
`else
            io_slave_rvalid  <= 1'b1;
            r_state          <= R_DATA;
`endif
          end
        end
`ifdef AXI_SRAM_LATENCY_EN
        R_WAIT: begin
          if (r_wait_cnt == LAT - 4'd1) begin
            io_slave_rvalid <= 1'b1;
            r_state         <= R_DATA;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
`endif
        R_DATA: begin
          if (io_slave_rready) begin
            if (r_cnt == r_len) begin
              io_slave_rvalid  <= 1'b0;
              io_slave_arready <= 1'b1;
              r_state          <= R_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              if (r_burst != 2'b00) r_addr <= r_addr + (32'd1 << r_size);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: single/partial/burst transfers, error responses and mid-burst reset.
module tb_axi4_sram_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic        arready, arvalid, rready, rvalid, rlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  int checks = 0;
  int failures = 0;

`ifdef AXI_SRAM_LATENCY_EN
  localparam int LAT_CYC = 3;
`else
  localparam int LAT_CYC = 0;
`endif

  axi4_sram_slave dut (
    .clock(clock), .reset(reset),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize), .io_slave_awburst(awburst),
    .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp), .io_slave_bid(bid),
    .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize), .io_slave_arburst(arburst),
    .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
    .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst;
    while (!awready && n < 50) begin tick(); n++; end
    checks++;
    if (!awready) begin failures++; $display("FAIL aw_handshake awready=%b required=1", awready); end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n;
    n = 0;
    wvalid = 1'b1; wdata = d; wstrb = strb; wlast = last;
    while (!wready && n < 50) begin tick(); n++; end
    checks++;
    if (!wready) begin failures++; $display("FAIL w_handshake wready=%b required=1", wready); end
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_get(output logic [1:0] resp, output logic [3:0] id);
    int n;
    n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin tick(); n++; end
    checks++;
    if (!bvalid) begin failures++; $display("FAIL b_handshake bvalid=%b required=1", bvalid); end
    resp = bresp; id = bid;
    tick();
    bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
    while (!arready && n < 50) begin tick(); n++; end
    checks++;
    if (!arready) begin failures++; $display("FAIL ar_handshake arready=%b required=1", arready); end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic r_get(output logic [31:0] d, output logic [1:0] resp, output logic last, output logic [3:0] id);
    int n;
    n = 0;
    rready = 1'b1;
    while (!rvalid && n < 50) begin tick(); n++; end
    checks++;
    if (!rvalid) begin failures++; $display("FAIL r_handshake rvalid=%b required=1", rvalid); end
    d = rdata; resp = rresp; last = rlast; id = rid;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 || rdata !== 32'h0 || bresp !== 2'b00)
      begin failures++; $display("FAIL reset_outputs aw=%b w=%b b=%b ar=%b r=%b rdata=%h required all 0", awready, wready, bvalid, arready, rvalid, rdata); end
    reset = 1'b1;
    tick();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1)
      begin failures++; $display("FAIL reset_release_ready awready=%b arready=%b required 1 1", awready, arready); end
  endtask

  task automatic test_single();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last;
    aw_send(32'h0f000010, 4'd5, 8'd0, 3'd2, 2'b01);
    w_send(32'hdeadbeef, 4'b1111, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b00 || id !== 4'd5) begin failures++; $display("FAIL single_b bresp=%b bid=%0d required 00 5", resp, id); end
    ar_send(32'h0f000010, 4'd9, 8'd0, 3'd2, 2'b01);
    repeat (LAT_CYC) tick();
    checks++;
    if (rvalid !== 1'b1) begin failures++; $display("FAIL single_r_latency rvalid=%b required=1", rvalid); end
    r_get(d, resp, last, id);
    checks++;
    if (d !== 32'hdeadbeef || resp !== 2'b00 || last !== 1'b1 || id !== 4'd9)
      begin failures++; $display("FAIL single_r rdata=%h rresp=%b rlast=%b rid=%0d required deadbeef 00 1 9", d, resp, last, id); end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last;
    aw_send(32'h0f000020, 4'd1, 8'd0, 3'd2, 2'b01);
    w_send(32'h11223344, 4'b1111, 1'b1);
    b_get(resp, id);
    aw_send(32'h0f000020, 4'd2, 8'd0, 3'd2, 2'b01);
    w_send(32'haabbccdd, 4'b0101, 1'b1);
    b_get(resp, id);
    ar_send(32'h0f000020, 4'd3, 8'd0, 3'd2, 2'b01);
    r_get(d, resp, last, id);
    checks++;
    if (d !== 32'h11bb33dd) begin failures++; $display("FAIL partial_strobe rdata=%h required 11bb33dd", d); end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp; logic [3:0] id; logic [31:0] exp_d;
    int beat, cyc;
    logic fire;
    aw_send(32'h0f000000, 4'd4, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'h10000000 + i, 4'b1111, i == 3);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b00 || id !== 4'd4) begin failures++; $display("FAIL incr_write_b bresp=%b bid=%0d required 00 4", resp, id); end
    ar_send(32'h0f000000, 4'd6, 8'd3, 3'd2, 2'b01);
    beat = 0; cyc = 0;
    while (beat < 4 && cyc < 40) begin
      rready = (cyc % 2 == 0);
      if (rvalid) begin
        exp_d = 32'h10000000 + beat;
        checks++;
        if (rdata !== exp_d || rlast !== (beat == 3) || rresp !== 2'b00 || rid !== 4'd6)
          begin failures++; $display("FAIL incr_read_beat%0d rdata=%h rlast=%b rresp=%b required %h %b 00", beat, rdata, rlast, rresp, exp_d, beat == 3); end
      end
      fire = rvalid && rready;
      tick();
      if (fire) beat++;
      cyc++;
    end
    rready = 1'b0;
    checks++;
    if (beat != 4 || rvalid !== 1'b0) begin failures++; $display("FAIL incr_read_count beats=%0d rvalid=%b required 4 0", beat, rvalid); end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    ar_send(32'h0f000000, 4'd7, 8'd3, 3'd2, 2'b01);
    rready = 1'b1;
    while (!rvalid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h10000000 + i)
        begin failures++; $display("FAIL b2b_beat%0d rvalid=%b rdata=%h required 1 %h", i, rvalid, rdata, 32'h10000000 + i); end
      tick();
    end
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL b2b_end rvalid=%b required 0", rvalid); end
  endtask

  task automatic test_fixed();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last;
    aw_send(32'h0f000040, 4'd8, 8'd2, 3'd2, 2'b00);
    w_send(32'h00000001, 4'b1111, 1'b0);
    w_send(32'h00000002, 4'b1111, 1'b0);
    w_send(32'h00000003, 4'b1111, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b00) begin failures++; $display("FAIL fixed_b bresp=%b required 00", resp); end
    ar_send(32'h0f000040, 4'd8, 8'd1, 3'd2, 2'b00);
    for (int i = 0; i < 2; i++) begin
      r_get(d, resp, last, id);
      checks++;
      if (d !== 32'h3 || last !== (i == 1)) begin failures++; $display("FAIL fixed_r%0d rdata=%h rlast=%b required 00000003 %b", i, d, last, i == 1); end
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last;
    aw_send(32'h0f001000, 4'd10, 8'd0, 3'd2, 2'b01);
    w_send(32'hcafef00d, 4'b1111, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b11 || id !== 4'd10) begin failures++; $display("FAIL oor_write_b bresp=%b bid=%0d required 11 10", resp, id); end
    ar_send(32'h0f000000, 4'd1, 8'd0, 3'd2, 2'b01);
    r_get(d, resp, last, id);
    checks++;
    if (d !== 32'h10000000) begin failures++; $display("FAIL oor_no_alias rdata=%h required 10000000", d); end
    ar_send(32'h0f001000, 4'd2, 8'd0, 3'd2, 2'b01);
    r_get(d, resp, last, id);
    checks++;
    if (d !== 32'h0 || resp !== 2'b11) begin failures++; $display("FAIL oor_read rdata=%h rresp=%b required 00000000 11", d, resp); end
    ar_send(32'h0efffffc, 4'd3, 8'd0, 3'd2, 2'b01);
    r_get(d, resp, last, id);
    checks++;
    if (d !== 32'h0 || resp !== 2'b11) begin failures++; $display("FAIL below_base_read rdata=%h rresp=%b required 00000000 11", d, resp); end
    aw_send(32'h0f000ffc, 4'd4, 8'd0, 3'd2, 2'b01);
    w_send(32'h5a5a5a5a, 4'b1111, 1'b1);
    b_get(resp, id);
    ar_send(32'h0f000ffc, 4'd4, 8'd0, 3'd2, 2'b01);
    r_get(d, resp, last, id);
    checks++;
    if (d !== 32'h5a5a5a5a || resp !== 2'b00) begin failures++; $display("FAIL top_word rdata=%h rresp=%b required 5a5a5a5a 00", d, resp); end
  endtask

  task automatic test_slverr();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last;
    aw_send(32'h0f000050, 4'd11, 8'd1, 3'd2, 2'b01);
    w_send(32'h00000077, 4'b1111, 1'b1);
    w_send(32'h00000088, 4'b1111, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b10 || id !== 4'd11) begin failures++; $display("FAIL early_wlast_b bresp=%b bid=%0d required 10 11", resp, id); end
    ar_send(32'h0f000050, 4'd12, 8'd1, 3'd2, 2'b10);
    for (int i = 0; i < 2; i++) begin
      r_get(d, resp, last, id);
      checks++;
      if (resp !== 2'b10 || last !== (i == 1)) begin failures++; $display("FAIL wrap_read%0d rresp=%b rlast=%b required 10 %b", i, resp, last, i == 1); end
    end
    aw_send(32'h0f000060, 4'd13, 8'd0, 3'd3, 2'b01);
    w_send(32'h00000099, 4'b1111, 1'b1);
    b_get(resp, id);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL big_size_b bresp=%b required 10", resp); end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last;
    int n;
    n = 0;
    ar_send(32'h0f000000, 4'd14, 8'd7, 3'd2, 2'b01);
    rready = 1'b1;
    while (!rvalid && n < 50) begin tick(); n++; end
    repeat (2) tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h10000002) begin failures++; $display("FAIL mid_burst_beat2 rvalid=%b rdata=%h required 1 10000002", rvalid, rdata); end
    reset = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || awready !== 1'b0 || rlast !== 1'b0)
      begin failures++; $display("FAIL mid_burst_reset rvalid=%b arready=%b awready=%b required 0 0 0", rvalid, arready, awready); end
    rready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin failures++; $display("FAIL post_reset arready=%b rvalid=%b required 1 0", arready, rvalid); end
    ar_send(32'h0f000010, 4'd15, 8'd0, 3'd2, 2'b01);
    r_get(d, resp, last, id);
    checks++;
    if (d !== 32'hdeadbeef || resp !== 2'b00 || last !== 1'b1 || id !== 4'd15)
      begin failures++; $display("FAIL post_reset_read rdata=%h rresp=%b rlast=%b rid=%0d required deadbeef 00 1 15", d, resp, last, id); end
  endtask

  initial begin
    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; rready = 1'b0;
    test_reset();
    test_single();
    test_partial_strobe();
    test_incr_burst();
    test_back_to_back();
    test_fixed();
    test_out_of_range();
    test_slverr();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
